apb_multi_slave_engine: RTL and testbench

Single-beat AXI4-Lite-to-APB engine that generalises the bridge's read/write sequencing to NUM_SLAVES APB targets with address decode, round-robin read/write arbitration, error-response mapping and an APB access timeout. It sits between the AXI slave port and the APB bus. It owns the AXI handshakes and the full APB SETUP/ACCESS protocol directly, so no separate read/write sub-engines are needed.

---
 rtl/bridge_utils.sv | 28 ++
 rtl/bridge_addr_decode.sv | 29 ++
 rtl/apb_multi_slave_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_apb_multi_slave_engine.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_utils.sv
// -----------------------------------------------------------------------------
// bridge_utils
//   Shared types for the AXI4-Lite to APB bridge family.
//   resp_t        : AXI response codes driven on rresp/bresp.
//   state_t       : sequencing states of the multi-slave engine.
//   access_type_t : read/write tag, also used for round-robin bookkeeping.
// -----------------------------------------------------------------------------
package bridge_utils;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } access_type_t;

endpackage

// File: rtl/bridge_addr_decode.sv
// -----------------------------------------------------------------------------
// bridge_addr_decode
//   Combinational address decode for the APB target windows.
//   addr_i    : AXI address of the granted request.
//   idx_o     : APB target index, taken from the bits just above the window.
//   dec_err_o : any address bit above the index field is set.
// -----------------------------------------------------------------------------
module bridge_addr_decode #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned NUM_SLAVES      = 4,
  parameter int unsigned SLAVE_ADDR_BITS = 12
) (
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  output logic [$clog2(NUM_SLAVES)-1:0] idx_o,
  output logic                          dec_err_o
);

  localparam int unsigned IDX_W = $clog2(NUM_SLAVES);
  localparam int unsigned HI    = SLAVE_ADDR_BITS + IDX_W;

  // Shifting the whole address keeps every bit visible to the reduction and
  // collapses cleanly to zero when the index field reaches the top bit.
  logic [ADDR_WIDTH-1:0] upper_bits;

  assign upper_bits = addr_i >> HI;
  assign idx_o      = addr_i[SLAVE_ADDR_BITS +: IDX_W];
  assign dec_err_o  = |upper_bits;

endmodule

// File: rtl/apb_multi_slave_engine.sv
// -----------------------------------------------------------------------------
// apb_multi_slave_engine
//   Single-beat AXI4-Lite slave that sequences APB SETUP/ACCESS to one of
//   NUM_SLAVES targets, with round-robin read/write arbitration, response
//   mapping (OKAY/SLVERR/DECERR) and an optional ACCESS-phase timeout.
//   clk_i/rst_ni          : clock, synchronous active-low reset.
//   ar*/aw*/w*            : AXI request channels (ready is combinational).
//   r*/b*                 : AXI response channels (registered).
//   paddr/pwrite/pwdata/pstrb/psel/penable : registered APB request.
//   pready/pslverr/prdata : per-target APB completion, packed by index.
// -----------------------------------------------------------------------------
module apb_multi_slave_engine
  import bridge_utils::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_SLAVES      = 4,
  parameter int unsigned SLAVE_ADDR_BITS = 12,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [ADDR_WIDTH-1:0]            araddr_i,
  input  logic                             arvalid_i,
  output logic                             arready_o,
  input  logic [ADDR_WIDTH-1:0]            awaddr_i,
  input  logic                             awvalid_i,
  output logic                             awready_o,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  input  logic [DATA_WIDTH/8-1:0]          wstrb_i,
  input  logic                             wvalid_i,
  output logic                             wready_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic [1:0]                       rresp_o,
  output logic                             rvalid_o,
  input  logic                             rready_i,
  output logic [1:0]                       bresp_o,
  output logic                             bvalid_o,
  input  logic                             bready_i,
  output logic [ADDR_WIDTH-1:0]            paddr_o,
  output logic                             pwrite_o,
  output logic [DATA_WIDTH-1:0]            pwdata_o,
  output logic [DATA_WIDTH/8-1:0]          pstrb_o,
  output logic [NUM_SLAVES-1:0]            psel_o,
  output logic                             penable_o,
  input  logic [NUM_SLAVES-1:0]            pready_i,
  input  logic [NUM_SLAVES-1:0]            pslverr_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_i
);

  localparam int unsigned IDX_W    = $clog2(NUM_SLAVES);
  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned CNT_W    = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TMO_LAST = TMO_EN ? TIMEOUT_CYCLES - 1 : 0;

  state_t                 state_q;
  access_type_t           type_q;
  access_type_t           last_grant_q;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       tmo_cnt_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic                   pwrite_q;
  logic [DATA_WIDTH-1:0]  pwdata_q;
  logic [STRB_W-1:0]      pstrb_q;
  logic [NUM_SLAVES-1:0]  psel_q;
  logic                   penable_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  resp_t                  rresp_q;
  resp_t                  bresp_q;
  logic                   rvalid_q;
  logic                   bvalid_q;

  logic                   in_idle;
  logic                   rd_req;
  logic                   wr_req;
  logic                   grant_rd;
  logic                   grant_wr;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [IDX_W-1:0]       dec_idx;
  logic                   dec_err;
  logic [NUM_SLAVES-1:0]  sel_onehot;
  logic [DATA_WIDTH-1:0]  prdata_arr [NUM_SLAVES];
  logic                   sel_pready;
  logic                   sel_pslverr;
  logic                   tmo_hit;
  logic                   acc_done;
  resp_t                  acc_resp;

  // Request eligibility and round-robin grant. Gating with rst_ni keeps the
  // ready outputs low while reset is held, so no handshake is ever lost.
  assign in_idle  = rst_ni && (state_q == ST_IDLE);
  assign rd_req   = arvalid_i;
  assign wr_req   = awvalid_i && wvalid_i;
  assign grant_rd = in_idle && rd_req && (!wr_req || last_grant_q == ACC_WRITE);
  assign grant_wr = in_idle && wr_req && (!rd_req || last_grant_q == ACC_READ);
  assign req_addr = grant_wr ? awaddr_i : araddr_i;

  assign arready_o = grant_rd;
  assign awready_o = grant_wr;
  assign wready_o  = grant_wr;

  bridge_addr_decode #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .NUM_SLAVES      (NUM_SLAVES),
    .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS)
  ) u_decode (
    .addr_i    (req_addr),
    .idx_o     (dec_idx),
    .dec_err_o (dec_err)
  );

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
    assign sel_onehot[gi] = (dec_idx == IDX_W'(gi));
    assign prdata_arr[gi] = prdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Only the captured target is looked at; other slaves' lines are don't-care.
  assign sel_pready  = pready_i[idx_q];
  assign sel_pslverr = pslverr_i[idx_q];
  assign tmo_hit     = TMO_EN && (tmo_cnt_q == CNT_W'(TMO_LAST));

  // pready is checked first so a completion on the timeout edge still wins.
  always_comb begin
    acc_done = 1'b0;
    acc_resp = RESP_OKAY;
    if (sel_pready) begin
      acc_done = 1'b1;
      acc_resp = sel_pslverr ? RESP_SLVERR : RESP_OKAY;
    end else if (tmo_hit) begin
      acc_done = 1'b1;
      acc_resp = RESP_SLVERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      type_q       <= ACC_READ;
      last_grant_q <= ACC_WRITE;
      idx_q        <= '0;
      tmo_cnt_q    <= '0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      bresp_q      <= RESP_OKAY;
      rvalid_q     <= 1'b0;
      bvalid_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_rd || grant_wr) begin
            type_q       <= grant_wr ? ACC_WRITE : ACC_READ;
            last_grant_q <= grant_wr ? ACC_WRITE : ACC_READ;
            paddr_q      <= req_addr;
            pwrite_q     <= grant_wr;
            pwdata_q     <= grant_wr ? wdata_i : '0;
            pstrb_q      <= grant_wr ? wstrb_i : '0;
            idx_q        <= dec_idx;
            tmo_cnt_q    <= '0;
            if (dec_err) begin
              // Unmapped address: answer straight away, APB stays idle.
              state_q <= ST_RESP;
              if (grant_wr) begin
                bvalid_q <= 1'b1;
                bresp_q  <= RESP_DECERR;
              end else begin
                rvalid_q <= 1'b1;
                rresp_q  <= RESP_DECERR;
                rdata_q  <= '0;
              end
            end else begin
              psel_q  <= sel_onehot;
              state_q <= ST_SETUP;
            end
          end
        end

        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (acc_done) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            state_q   <= ST_RESP;
            if (type_q == ACC_WRITE) begin
              bvalid_q <= 1'b1;
              bresp_q  <= acc_resp;
            end else begin
              rvalid_q <= 1'b1;
              rresp_q  <= acc_resp;
              rdata_q  <= (acc_resp == RESP_OKAY) ? prdata_arr[idx_q] : '0;
            end
          end else if (TMO_EN) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end

        ST_RESP: begin
          if (type_q == ACC_READ && rready_i) begin
            rvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (type_q == ACC_WRITE && bready_i) begin
            bvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign paddr_o   = paddr_q;
  assign pwrite_o  = pwrite_q;
  assign pwdata_o  = pwdata_q;
  assign pstrb_o   = pstrb_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rvalid_o  = rvalid_q;
  assign bresp_o   = bresp_q;
  assign bvalid_o  = bvalid_q;

endmodule

// File: tb/tb_apb_multi_slave_engine.sv
// -----------------------------------------------------------------------------
// tb_apb_multi_slave_engine
//   Self-checking bench: a directed vector table, hand-written sequences for
//   arbitration, response back-pressure and mid-access reset, then random
//   transactions compared against a rule-level response model.
// -----------------------------------------------------------------------------
module tb_apb_multi_slave_engine;

  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   araddr, awaddr, wdata, rdata, paddr, pwdata;
  logic          arvalid, arready, awvalid, awready, wvalid, wready;
  logic [3:0]    wstrb, pstrb, psel, pready, pslverr;
  logic [1:0]    rresp, bresp;
  logic          rvalid, rready, bvalid, bready, pwrite, penable;
  logic [NS*DW-1:0] prdata;

  always #5 clk = ~clk;

  apb_multi_slave_engine #(
    .ADDR_WIDTH(32), .DATA_WIDTH(DW), .NUM_SLAVES(NS),
    .SLAVE_ADDR_BITS(12), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .psel_o(psel), .penable_o(penable),
    .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata)
  );

  // ---------------- APB slave models ----------------
  int          slave_wait [NS];
  bit          slave_err  [NS];
  logic [31:0] slave_rd   [NS];
  logic [NS-1:0] noise_rdy = '0, noise_err = '0;
  logic [31:0] noise_rd [NS];
  int          acc_cnt = 0;
  logic        sel_rdy;

  always_comb begin
    pready  = '0;
    pslverr = '0;
    prdata  = '0;
    for (int i = 0; i < NS; i++) begin
      pready[i]           = psel[i] ? (penable && acc_cnt >= slave_wait[i]) : noise_rdy[i];
      pslverr[i]          = psel[i] ? slave_err[i] : noise_err[i];
      prdata[i*DW +: DW]  = psel[i] ? slave_rd[i] : noise_rd[i];
    end
  end
  assign sel_rdy = |(psel & pready);

  always @(posedge clk) begin
    if (penable && !sel_rdy) acc_cnt <= acc_cnt + 1;
    else                     acc_cnt <= 0;
  end

  // Unselected targets toggle their lines randomly; the engine must ignore them.
  always @(negedge clk) begin
    noise_rdy <= NS'($urandom);
    noise_err <= NS'($urandom);
    for (int i = 0; i < NS; i++) noise_rd[i] <= $urandom;
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Response model from the protocol rules: window decode, wait states against
  // the timeout budget, slave error flag.
  function automatic void model(input bit is_wr, input logic [31:0] addr,
                                output logic [1:0] resp, output logic [31:0] rd,
                                output int lat);
    int s;
    if ((addr >> 14) != 0) begin
      resp = 2'd3; rd = '0; lat = 1;
    end else begin
      s = int'(addr[13:12]);
      if (slave_wait[s] + 1 > TMO) begin
        resp = 2'd2; lat = 2 + TMO;
      end else begin
        resp = slave_err[s] ? 2'd2 : 2'd0; lat = 3 + slave_wait[s];
      end
      rd = (!is_wr && resp == 2'd0) ? slave_rd[s] : 32'h0;
    end
  endfunction

  task automatic set_slave(input logic [31:0] addr, input int w, input bit e, input logic [31:0] d);
    int s;
    s = int'(addr[13:12]);
    slave_wait[s] = w; slave_err[s] = e; slave_rd[s] = d;
  endtask

  // One AXI transaction; called at a negedge, returns at a negedge with the
  // engine back in IDLE. hold = cycles the response is back-pressured.
  task automatic run_txn(input string tag, input bit is_wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] ws, input int hold,
                         input logic [1:0] exp_resp, input logic [31:0] exp_rdata,
                         input int exp_lat);
    int lat; bit granted, proto_ok, stable_ok;
    logic [3:0] exp_psel; logic [1:0] got_resp; logic [31:0] got_rd;
    exp_psel = ((addr >> 14) != 0) ? 4'b0000 : (4'b0001 << addr[13:12]);
    rready = (hold == 0); bready = (hold == 0);
    if (is_wr) begin
      awaddr = addr; wdata = wd; wstrb = ws; awvalid = 1'b1; wvalid = 1'b1;
    end else begin
      araddr = addr; arvalid = 1'b1;
    end
    granted = 1'b0;
    for (int i = 0; i < 20 && !granted; i++) begin
      #1;
      granted = is_wr ? (awready && wready && !arready) : (arready && !awready);
      if (!granted) @(negedge clk);
    end
    chk({tag, " grant"}, 32'(granted), 32'd1);
    if (!granted) begin
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b1; bready = 1'b1;
      @(negedge clk);
      return;
    end
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    lat = 1; proto_ok = 1'b1;
    while (lat < 60 && !(is_wr ? bvalid : rvalid)) begin
      if (psel !== exp_psel || penable !== (lat > 1) || pwrite !== is_wr ||
          paddr !== addr || pstrb !== (is_wr ? ws : 4'b0000) ||
          (is_wr && pwdata !== wd))
        proto_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    got_resp = is_wr ? bresp : rresp;
    got_rd   = rdata;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " apb phases"}, 32'(proto_ok), 32'd1);
    chk({tag, " apb idle at resp"}, 32'({psel, penable}), 32'd0);
    chk({tag, " resp"}, 32'(got_resp), 32'(exp_resp));
    if (!is_wr) chk({tag, " rdata"}, got_rd, exp_rdata);
    stable_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!(is_wr ? bvalid : rvalid) || (is_wr ? bresp : rresp) !== got_resp ||
          (!is_wr && rdata !== got_rd))
        stable_ok = 1'b0;
    end
    if (hold > 0) chk({tag, " resp held"}, 32'(stable_ok), 32'd1);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    chk({tag, " valid drop"}, 32'({rvalid, bvalid}), 32'd0);
    $display("TXN %s %s addr=%h resp=%0d rdata=%h lat=%0d hold=%0d",
             tag, is_wr ? "WR" : "RD", addr, got_resp, got_rd, lat, hold);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          is_wr;
    logic [31:0] addr, wd;
    logic [3:0]  ws;
    int          swait;
    bit          serr;
    logic [31:0] srd;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vt [10];

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] mresp; logic [31:0] mrd, a; int mlat, s, r, lat;
    bit model_last_wr, exp_wr, got_wr, ok, saw;

    for (int i = 0; i < NS; i++) begin
      slave_wait[i] = 0; slave_err[i] = 1'b0; slave_rd[i] = '0; noise_rd[i] = '0;
    end
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    rst_n = 1'b0; arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    rready = 1'b1; bready = 1'b1;
    @(negedge clk); @(negedge clk);

    // Reset state, with requests pending the whole time.
    chk("reset readies", 32'({arready, awready, wready}), 32'd0);
    chk("reset valids", 32'({rvalid, bvalid}), 32'd0);
    chk("reset psel/penable", 32'({psel, penable}), 32'd0);
    chk("reset paddr", paddr, 32'd0);
    chk("reset pwdata", pwdata, 32'd0);
    chk("reset pstrb/pwrite", 32'({pstrb, pwrite}), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset resps", 32'({rresp, bresp}), 32'd0);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    //          wr    addr           wdata          strb     wait serr srd            resp   rdata          lat
    vt[0] = '{1'b0, 32'h0000_1004, 32'h0,         4'b0000, 0,   0,   32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 3};
    vt[1] = '{1'b1, 32'h0000_3000, 32'h1234_5678, 4'b0011, 3,   0,   32'h0,         2'd0, 32'h0,         6};
    vt[2] = '{1'b0, 32'h0001_0000, 32'h0,         4'b0000, 0,   0,   32'h0,         2'd3, 32'h0,         1};
    vt[3] = '{1'b0, 32'h0000_2008, 32'h0,         4'b0000, 255, 0,   32'h1111_2222, 2'd2, 32'h0,         18};
    vt[4] = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 0,   1,   32'h0000_0055, 2'd2, 32'h0,         3};
    vt[5] = '{1'b1, 32'h0000_2000, 32'hA5A5_0F0F, 4'b1111, 15,  0,   32'h0,         2'd0, 32'h0,         18};
    vt[6] = '{1'b1, 32'h0000_1FFC, 32'h0BAD_F00D, 4'b0100, 16,  0,   32'h0,         2'd2, 32'h0,         18};
    vt[7] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1111, 0,   0,   32'h0,         2'd3, 32'h0,         1};
    vt[8] = '{1'b0, 32'h0000_3FFC, 32'h0,         4'b0000, 15,  0,   32'hCAFE_F00D, 2'd0, 32'hCAFE_F00D, 18};
    vt[9] = '{1'b0, 32'h0000_1000, 32'h0,         4'b0000, 16,  0,   32'h0000_0077, 2'd2, 32'h0,         18};

    for (int i = 0; i < 10; i++) begin
      set_slave(vt[i].addr, vt[i].swait, vt[i].serr, vt[i].srd);
      run_txn($sformatf("vec%0d", i), vt[i].is_wr, vt[i].addr, vt[i].wd, vt[i].ws,
              i % 3, vt[i].resp, vt[i].rdata, vt[i].lat);
    end

    // Contested requests after reset: R, W, R, W.
    do_reset();
    set_slave(32'h0, 0, 1'b0, 32'h0000_ABCD);
    araddr = 32'h0000_0010; awaddr = 32'h0000_0020; wdata = 32'h5555_AAAA; wstrb = 4'hF;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    model_last_wr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_wr = !model_last_wr;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        #1;
        ok = arready || (awready && wready);
        if (!ok) @(negedge clk);
      end
      got_wr = awready && wready;
      chk($sformatf("arb single grant %0d", k), 32'(arready && awready), 32'd0);
      chk($sformatf("arb grant type %0d", k), 32'(got_wr), 32'(exp_wr));
      model_last_wr = exp_wr;
      @(negedge clk);
      lat = 1;
      while (lat < 30 && !(rvalid || bvalid)) begin @(negedge clk); lat++; end
      chk($sformatf("arb latency %0d", k), 32'(lat), 32'd3);
      $display("ARB %0d granted %s lat=%0d", k, got_wr ? "WR" : "RD", lat);
      @(negedge clk);
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);

    // Reset while in ACCESS on a target that never answers.
    set_slave(32'h0000_2000, 255, 1'b0, 32'h0);
    araddr = 32'h0000_2000; arvalid = 1'b1; rready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin #1; ok = arready; if (!ok) @(negedge clk); end
    chk("rst-mid grant", 32'(ok), 32'd1);
    @(negedge clk); arvalid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("rst-mid in access", 32'({psel, penable}), 32'b01001);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst-mid apb dropped", 32'({psel, penable}), 32'd0);
    chk("rst-mid no rvalid", 32'(rvalid), 32'd0);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (rvalid || bvalid || penable) saw = 1'b1; end
    chk("rst-mid dropped txn", 32'(saw), 32'd0);
    $display("RST mid-access reset applied");
    set_slave(32'h0000_1000, 0, 1'b0, 32'h0BEE_F001);
    run_txn("post-rst", 1'b0, 32'h0000_1008, 32'h0, 4'h0, 0, 2'd0, 32'h0BEE_F001, 3);

    // Random transactions against the rule model.
    for (int n = 0; n < 40; n++) begin
      s = $urandom_range(0, 3);
      a = {18'b0, 2'(s), 10'($urandom), 2'b00};
      if ($urandom_range(0, 5) == 0) a = a | (32'h1 << $urandom_range(14, 31));
      r = $urandom_range(0, 9);
      set_slave(a, (r < 7) ? (r % 4) : (r == 7) ? 15 : (r == 8) ? 16 : 255,
                ($urandom_range(0, 3) == 0), $urandom);
      ok = ($urandom_range(0, 1) == 1);
      model(ok, a, mresp, mrd, mlat);
      run_txn($sformatf("rnd%0d", n), ok, a, $urandom, 4'($urandom),
              $urandom_range(0, 2), mresp, mrd, mlat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
